rr_arbiter_four: RTL and testbench
==================================

// Module: rr_arbiter_four
// PURPOSE
//   Round-robin arbiter for four requesters. Sits directly upstream of the 4:1 selector
//   and drives its 2-bit select with the index of the granted requester.
//   Each grant is held until the owner signals done, drops its request, or exceeds MAX_HOLD.
//   A 1-cycle gap separates grants so the downstream mux output settles between owners.
// PARAMETERS
//   MAX_HOLD  16  max cycles a grant may be held; 0 disables the timeout
//   CNT_W      5  hold-counter width; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//   clk          input   1  single clock, all state updates on rising edge
//   rst          input   1  synchronous active-high reset
//   req          input   4  request lines, bit i = requester i, level-sensitive
//   done         input   1  1-cycle pulse from current owner: release grant
//   sel          output  2  binary index of granted requester, feeds selector sel[1:0]
//   grant        output  4  one-hot grant, bit sel set while grant_valid
//   grant_valid  output  1  high while a grant is held
//   timeout      output  1  1-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//   Clock/reset: one clock (clk); reset (rst) is synchronous and active-high.
//   Reset: state=IDLE, ptr=0, hold_cnt=0, sel=2'b00, grant=4'b0000,
//     grant_valid=0, timeout=0. Reset wins over every other event in the same cycle.
//   All outputs are registered; there is no combinational path from req/done to outputs.
//   States
//     IDLE : no grant. If req!=0, choose first set bit scanning ptr, ptr+1, .. ptr+3
//            (mod 4) -> idx. Next cycle: GRANT, sel=idx, grant=1<<idx, grant_valid=1,
//            hold_cnt=0. If req==0, stay IDLE.
//     GRANT: hold_cnt increments each cycle (saturating). Release when any holds:
//            done=1, req[sel]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
//            On release: next cycle -> GAP, grant=0, grant_valid=0, ptr=sel+1 (mod 4,
//            2-bit wrap 3->0), sel keeps its last value.
//            timeout=1 for that one cycle only if release was by hold limit alone
//            (done=0 and req[sel]=1).
//     GAP  : exactly 1 cycle, timeout back to 0, no grant. Next cycle -> IDLE.
//            IDLE arbitrates that same cycle, so the minimum grant-to-grant spacing
//            is 2 cycles with grant_valid low.
//   Latency: req rising in IDLE -> grant_valid high 1 cycle later.
//   Fairness: the releasing owner has the lowest priority on the next arbitration.
//     With all four requesting continuously, grant order is 0,1,2,3,0,...
//   Boundaries
//     - done in IDLE/GAP is ignored; done and req[sel] drop in the same cycle give one release.
//     - Requests from non-owners during GRANT have no effect until the next arbitration.
//     - MAX_HOLD=1: grant lasts exactly 1 cycle, then revoked with a timeout pulse
//       unless done was also high.
//     - rst mid-GRANT: the next edge returns to the reset values, with no timeout pulse.
//     - grant is always one-hot or zero; grant_valid == |grant.
// TESTING
//   1 Reset then req=4'b0000 for 10 cycles -> sel=0, grant=0, grant_valid=0, timeout=0 throughout.
//   2 req=4'b0100 from cycle 0 -> cycle 1 grant=4'b0100, sel=2; done at cycle 4
//     -> cycle 5 grant=0; cycle 5 timeout=0.
//   3 req=4'b1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0,
//     with 2 idle cycles between grants.
//   4 MAX_HOLD=16, req=4'b0001 held, no done -> grant_valid high 16 cycles, then
//     timeout=1 for 1 cycle; next grant is again 0 (sole requester).
//   5 Owner 3 drops req[3] while req=4'b0011 -> release, ptr wraps to 0, next grant=4'b0001.
//   6 rst asserted in GRANT with hold_cnt=5 -> next cycle all outputs at reset values,
//     timeout=0; after rst releases, req=4'b0010 grants sel=1 in 1 cycle.

Source files
------------

// File: rtl/rr_arbiter_four_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives requests and done; the slave side is the arbiter.
interface rr_arbiter_four_if;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  sel,
        input  grant,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output sel,
        output grant,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_four.sv
// Round-robin arbiter for four requesters driving a 4:1 selector.
// A grant is held until done, request drop, or MAX_HOLD expiry; a one-cycle
// gap separates successive owners so the downstream mux settles.
module rr_arbiter_four #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    rr_arbiter_four_if.slave  arb
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       grant_q, grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             found;
    logic             owner_req;
    logic             hit_limit;
    logic             release_now;

    // Rotating priority scan starting at ptr; first set request wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && arb.req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Release conditions for the current owner.
    always_comb begin
        owner_req   = arb.req[sel_q];
        hit_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        release_now = arb.done || !owner_req || hit_limit;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        sel_d         = sel_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = GRANT;
                    sel_d         = pick;
                    grant_d       = 4'b0001 << pick;
                    grant_valid_d = 1'b1;
                    hold_cnt_d    = '0;
                end
            end
            GRANT: begin
                if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                if (release_now) begin
                    state_d       = GAP;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    ptr_d         = sel_q + 2'd1;
                    // Only a pure hold-limit release flags a timeout.
                    timeout_d     = !arb.done && owner_req;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            sel_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            sel_q         <= sel_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign arb.sel         = sel_q;
    assign arb.grant       = grant_q;
    assign arb.grant_valid = grant_valid_q;
    assign arb.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_four.sv
// Bench for rr_arbiter_four: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of ownership.
module tb_rr_arbiter_four;

    logic       clk;
    logic       rst_r;
    logic [3:0] req_r;
    logic       done_r;
    int         n_cmp;
    int         n_bad;

    rr_arbiter_four_if ifa ();
    rr_arbiter_four_if ifb ();

    assign ifa.req  = req_r;
    assign ifa.done = done_r;
    assign ifb.req  = req_r;
    assign ifb.done = done_r;

    rr_arbiter_four #(.MAX_HOLD(16), .CNT_W(5)) dut_a (
        .clk (clk),
        .rst (rst_r),
        .arb (ifa.slave)
    );

    rr_arbiter_four #(.MAX_HOLD(1), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst_r),
        .arb (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: owner (-1 none), cycles owned so far, cycles before arbitration
    // may resume, first index to scan, last granted index, timeout pulse.
    int m_owner [2];
    int m_held  [2];
    int m_cool  [2];
    int m_first [2];
    int m_sel   [2];
    bit m_to    [2];
    int m_limit [2];

    task automatic model_step(input int k);
        if (rst_r) begin
            m_owner[k] = -1; m_held[k] = 0; m_cool[k] = 0;
            m_first[k] = 0;  m_sel[k]  = 0; m_to[k]   = 1'b0;
        end else if (m_owner[k] >= 0) begin
            m_to[k] = 1'b0;
            if (done_r || !req_r[m_owner[k]] || (m_limit[k] != 0 && m_held[k] >= m_limit[k])) begin
                m_to[k]    = !done_r && req_r[m_owner[k]];
                m_first[k] = (m_owner[k] + 1) % 4;
                m_owner[k] = -1;
                m_cool[k]  = 1;
            end else begin
                m_held[k]++;
            end
        end else begin
            m_to[k] = 1'b0;
            if (m_cool[k] > 0) begin
                m_cool[k]--;
            end else begin
                for (int j = 0; j < 4; j++) begin
                    if (m_owner[k] < 0 && req_r[(m_first[k] + j) % 4]) m_owner[k] = (m_first[k] + j) % 4;
                end
                if (m_owner[k] >= 0) begin
                    m_held[k] = 1;
                    m_sel[k]  = m_owner[k];
                end
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic do_reset;
        rst_r  = 1'b1;
        req_r  = 4'b0000;
        done_r = 1'b0;
        tick;
        rst_r  = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        for (int c = 0; c < 10; c++) begin
            tick;
            n_cmp++;
            if ({ifa.sel, ifa.grant, ifa.grant_valid, ifa.timeout} !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_idle c%0d: got sel=%0d grant=%b gv=%b to=%b want all zero",
                         c, ifa.sel, ifa.grant, ifa.grant_valid, ifa.timeout);
            end
        end
    endtask

    task automatic test_single;
        do_reset;
        req_r = 4'b0100;
        tick;
        n_cmp++;
        if (ifa.grant !== 4'b0100 || ifa.sel !== 2'd2 || ifa.grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_grant: got grant=%b sel=%0d gv=%b want 0100/2/1", ifa.grant, ifa.sel, ifa.grant_valid);
        end
        for (int c = 2; c <= 4; c++) begin
            tick;
            n_cmp++;
            if (ifa.grant !== 4'b0100) begin
                n_bad++;
                $display("FAIL single_hold c%0d: got grant=%b want 0100", c, ifa.grant);
            end
        end
        done_r = 1'b1;
        tick;
        done_r = 1'b0;
        n_cmp++;
        if (ifa.grant !== 4'b0000 || ifa.grant_valid !== 1'b0 || ifa.timeout !== 1'b0 || ifa.sel !== 2'd2) begin
            n_bad++;
            $display("FAIL single_done: got grant=%b gv=%b to=%b sel=%0d want 0000/0/0/2",
                     ifa.grant, ifa.grant_valid, ifa.timeout, ifa.sel);
        end
    endtask

    task automatic test_round_robin;
        int n;
        int gap;
        int cyc;
        logic [3:0] exp_g;
        do_reset;
        req_r = 4'b1111;
        n = 0; gap = 0; cyc = 0;
        while (n < 5 && cyc < 60) begin
            tick;
            cyc++;
            if (ifa.grant_valid) begin
                exp_g = 4'b0001 << (n % 4);
                n_cmp++;
                if (ifa.sel !== 2'(n % 4) || ifa.grant !== exp_g) begin
                    n_bad++;
                    $display("FAIL rr_order #%0d: got sel=%0d grant=%b want sel=%0d grant=%b",
                             n, ifa.sel, ifa.grant, n % 4, exp_g);
                end
                if (n > 0) begin
                    n_cmp++;
                    if (gap !== 2) begin
                        n_bad++;
                        $display("FAIL rr_gap #%0d: got %0d idle cycles want 2", n, gap);
                    end
                end
                n++;
                gap = 0;
                done_r = 1'b1;
            end else begin
                gap++;
                done_r = 1'b0;
            end
        end
        done_r = 1'b0;
        n_cmp++;
        if (n !== 5) begin
            n_bad++;
            $display("FAIL rr_count: got %0d grants want 5 within budget", n);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        do_reset;
        req_r = 4'b0001;
        tick;
        cnt = 0;
        while (ifa.grant_valid && cnt < 40) begin
            cnt++;
            tick;
        end
        n_cmp++;
        if (cnt !== 16 || ifa.timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_len: got %0d cycles to=%b want 16 cycles to=1", cnt, ifa.timeout);
        end
        tick;
        n_cmp++;
        if (ifa.timeout !== 1'b0 || ifa.grant_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_pulse: got to=%b gv=%b want 0/0", ifa.timeout, ifa.grant_valid);
        end
        tick;
        n_cmp++;
        if (ifa.grant !== 4'b0001 || ifa.sel !== 2'd0) begin
            n_bad++;
            $display("FAIL timeout_regrant: got grant=%b sel=%0d want 0001/0", ifa.grant, ifa.sel);
        end
    endtask

    task automatic test_wrap;
        do_reset;
        req_r = 4'b1000;
        tick;
        n_cmp++;
        if (ifa.grant !== 4'b1000 || ifa.sel !== 2'd3) begin
            n_bad++;
            $display("FAIL wrap_grant3: got grant=%b sel=%0d want 1000/3", ifa.grant, ifa.sel);
        end
        req_r = 4'b0011;
        tick;
        n_cmp++;
        if (ifa.grant_valid !== 1'b0 || ifa.timeout !== 1'b0 || ifa.sel !== 2'd3) begin
            n_bad++;
            $display("FAIL wrap_release: got gv=%b to=%b sel=%0d want 0/0/3", ifa.grant_valid, ifa.timeout, ifa.sel);
        end
        tick;
        tick;
        n_cmp++;
        if (ifa.grant !== 4'b0001 || ifa.sel !== 2'd0) begin
            n_bad++;
            $display("FAIL wrap_next: got grant=%b sel=%0d want 0001/0", ifa.grant, ifa.sel);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        req_r = 4'b0100;
        tick;
        repeat (5) tick;
        n_cmp++;
        if (ifa.grant_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_held: got gv=%b want 1", ifa.grant_valid);
        end
        rst_r = 1'b1;
        tick;
        rst_r = 1'b0;
        n_cmp++;
        if ({ifa.sel, ifa.grant, ifa.grant_valid, ifa.timeout} !== 8'h00) begin
            n_bad++;
            $display("FAIL midrst_values: got sel=%0d grant=%b gv=%b to=%b want all zero",
                     ifa.sel, ifa.grant, ifa.grant_valid, ifa.timeout);
        end
        req_r = 4'b0010;
        tick;
        n_cmp++;
        if (ifa.grant !== 4'b0010 || ifa.sel !== 2'd1) begin
            n_bad++;
            $display("FAIL midrst_regrant: got grant=%b sel=%0d want 0010/1", ifa.grant, ifa.sel);
        end
    endtask

    task automatic test_hold_one;
        do_reset;
        req_r = 4'b0001;
        tick;
        n_cmp++;
        if (ifb.grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL hold1_grant: got grant=%b want 0001", ifb.grant);
        end
        tick;
        n_cmp++;
        if (ifb.grant_valid !== 1'b0 || ifb.timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL hold1_revoke: got gv=%b to=%b want 0/1", ifb.grant_valid, ifb.timeout);
        end
        tick;
        tick;
        n_cmp++;
        if (ifb.grant !== 4'b0001) begin
            n_bad++;
            $display("FAIL hold1_regrant: got grant=%b want 0001", ifb.grant);
        end
        done_r = 1'b1;
        tick;
        done_r = 1'b0;
        n_cmp++;
        if (ifb.grant_valid !== 1'b0 || ifb.timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL hold1_done: got gv=%b to=%b want 0/0", ifb.grant_valid, ifb.timeout);
        end
    endtask

    task automatic test_random;
        logic [3:0] exp_g;
        logic [7:0] got;
        logic [7:0] exp;
        do_reset;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) req_r = 4'($urandom_range(15));
            done_r = ($urandom_range(9) == 0);
            rst_r  = ($urandom_range(199) == 0);
            tick;
            for (int k = 0; k < 2; k++) begin
                exp_g = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
                exp   = {2'(m_sel[k]), exp_g, m_owner[k] >= 0, m_to[k]};
                got   = (k == 0) ? {ifa.sel, ifa.grant, ifa.grant_valid, ifa.timeout}
                                 : {ifb.sel, ifb.grant, ifb.grant_valid, ifb.timeout};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL random dut%0d c%0d: got {sel,grant,gv,to}=%b want %b", k, c, got, exp);
                end
            end
        end
        rst_r  = 1'b0;
        done_r = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_r  = 1'b1;
        req_r  = 4'b0000;
        done_r = 1'b0;
        m_limit[0] = 16;
        m_limit[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_held[k] = 0; m_cool[k] = 0;
            m_first[k] = 0;  m_sel[k]  = 0; m_to[k]   = 1'b0;
        end
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_wrap;
        test_reset_mid;
        test_hold_one;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
